// File: rtl/serial_flit_tx.sv
// Parallel-to-serial flit transmitter: small flit FIFO feeding a framed,
// LSB-first serial line (start 0, FLIT_W data bits, stop 1) that idles high.
module serial_flit_tx #(
  parameter int FLIT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FLIT_W-1:0]             flit_i,
  input  logic                          flit_valid_i,
  output logic                          flit_ready_o,
  output logic                          out_sflit_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FLIT_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FLIT_W - 1);

  // Flit storage: no reset; contents are only meaningful between the pointers.
  logic [FLIT_W-1:0] mem [FIFO_DEPTH];

  logic [PTR_W:0]     wr_ptr_reg;
  logic [PTR_W:0]     rd_ptr_reg;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               launch;

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic [FLIT_W-1:0]  shift_reg;
  logic [FLIT_W-1:0]  shift_next;
  logic               line_reg;
  logic               line_next;

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                  (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // Ready is strictly !full: a pop in the same cycle does not free a slot early.
  assign push   = flit_valid_i && !full;
  assign launch = !empty && out_ready_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= flit_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // line_next is the level of the state being entered, so the line is a pure flop output.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    line_next    = line_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE, STOP: begin
        if (launch) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg[PTR_W-1:0]];
          state_next = START;
          line_next  = 1'b0;
        end else begin
          state_next = IDLE;
          line_next  = 1'b1;
        end
      end
      START: begin
        state_next   = DATA;
        bit_cnt_next = '0;
        line_next    = shift_reg[0];
      end
      DATA: begin
        shift_next = shift_reg >> 1;
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = STOP;
          line_next  = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          line_next    = shift_reg[1];
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      line_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      line_reg    <= line_next;
    end
  end

  assign out_sflit_o  = line_reg;
  assign busy_o       = (state_reg != IDLE);
  assign flit_ready_o = !full;
  assign fifo_count_o = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: tb/tb_serial_flit_tx.sv
// Directed bench for serial_flit_tx (FLIT_W=8, FIFO_DEPTH=4): per-cycle vector
// table plus hand-written multi-cycle sequences and a serial frame decoder.
module tb_serial_flit_tx;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] flit;
  logic         flit_valid;
  logic         flit_ready;
  logic         sflit;
  logic         out_ready;
  logic         busy;
  logic [2:0]   count;

  always #5 clk = ~clk;

  serial_flit_tx #(.FLIT_W(W), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .flit_i       (flit),
    .flit_valid_i (flit_valid),
    .flit_ready_o (flit_ready),
    .out_sflit_o  (sflit),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .fifo_count_o (count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent frame decoder on the serial line.
  logic [W-1:0] rx_q[$];
  int           mon_phase = 0;
  logic [W-1:0] mon_data;
  always begin
    @(posedge clk);
    #1;
    if (reset === 1'b1) begin
      mon_phase = 0;
    end else if (mon_phase == 0) begin
      if (sflit === 1'b0) mon_phase = 1;
    end else if (mon_phase <= W) begin
      mon_data[mon_phase-1] = sflit;
      mon_phase++;
    end else begin
      check("stop_bit", sflit, 1);
      rx_q.push_back(mon_data);
      $display("rx frame %02h", mon_data);
      mon_phase = 0;
    end
  end

  typedef struct {
    logic         v;
    logic [W-1:0] f;
    logic         r;
    logic         line;
    logic         busy;
    logic [2:0]   cnt;
    logic         frdy;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic v, input logic [W-1:0] f, input logic r,
                     input logic line, input logic b, input logic [2:0] c, input logic frdy);
    vec_t e;
    e.v = v; e.f = f; e.r = r; e.line = line; e.busy = b; e.cnt = c; e.frdy = frdy;
    vecs.push_back(e);
  endtask

  initial begin
    logic [W-1:0] b;
    logic         exp_bits[$];
    int           peak;

    reset = 1'b1; flit_valid = 1'b0; flit = '0; out_ready = 1'b0;
    #2;
    check("rst_line", sflit, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ready", flit_ready, 1);
    step(); step();
    reset = 1'b0;

    // Frame of 0xA5 with receiver ready, then 0x3C held until ready rises.
    b = 8'hA5;
    add(1, b, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < W; i++) add(0, 0, 1, b[i], 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1);
    b = 8'h3C;
    add(1, b, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < W; i++) add(0, 0, 1, b[i], 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1);

    foreach (vecs[i]) begin
      flit_valid = vecs[i].v;
      flit       = vecs[i].v ? vecs[i].f : 'x;
      out_ready  = vecs[i].r;
      step();
      check($sformatf("vec%0d_line", i), sflit, vecs[i].line);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      check($sformatf("vec%0d_ready", i), flit_ready, vecs[i].frdy);
    end
    check("tbl_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("tbl_rx0", rx_q[0], 8'hA5);
      check("tbl_rx1", rx_q[1], 8'h3C);
    end

    // Four back-to-back frames.
    rx_q.delete();
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < W; i++) exp_bits.push_back(b[i]);
      exp_bits.push_back(1'b1);
    end
    peak = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (c < 4) begin flit_valid = 1'b1; flit = 8'(c + 1); end
      else begin flit_valid = 1'b0; flit = 'x; end
      step();
      if (int'(count) > peak) peak = int'(count);
      if (c >= 1 && c <= 40) check($sformatf("b2b_bit%0d", c - 1), sflit, exp_bits[c-1]);
    end
    check("b2b_peak", peak, 3);
    check("b2b_idle", busy, 0);
    check("b2b_rx_n", rx_q.size(), 4);

    // Fill to full, reject extra pushes, then push and pop in one cycle.
    rx_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flit_valid = 1'b1; flit = 8'(8'h10 + i);
      step();
      check($sformatf("fill%0d_count", i), count, (i < 4) ? i + 1 : 4);
      check($sformatf("fill%0d_ready", i), flit_ready, (i < 3) ? 1 : 0);
    end
    flit = 8'h99; out_ready = 1'b1;
    step();
    check("full_pop_count", count, 3);
    check("full_pop_line", sflit, 0);
    flit_valid = 1'b0; flit = 'x;
    for (int i = 0; i < 9; i++) step();
    check("pre_pp_stop", sflit, 1);
    flit_valid = 1'b1; flit = 8'h15;
    step();
    check("pushpop_count", count, 3);
    check("pushpop_line", sflit, 0);
    flit_valid = 1'b0; flit = 'x;
    for (int i = 0; i < 45; i++) step();
    check("full_rx_n", rx_q.size(), 5);
    if (rx_q.size() == 5) begin
      check("full_rx0", rx_q[0], 8'h10);
      check("full_rx1", rx_q[1], 8'h11);
      check("full_rx2", rx_q[2], 8'h12);
      check("full_rx3", rx_q[3], 8'h13);
      check("full_rx4", rx_q[4], 8'h15);
    end
    check("full_drained", count, 0);

    // Ready dropped mid-frame: frame completes, next waits for ready.
    rx_q.delete();
    out_ready = 1'b1;
    flit_valid = 1'b1; flit = 8'h5A; step();
    flit = 8'h77; step();
    flit_valid = 1'b0; flit = 'x;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("drop_stop_busy", busy, 1);
    check("drop_stop_line", sflit, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drop_wait%0d_busy", i), busy, 0);
      check($sformatf("drop_wait%0d_count", i), count, 1);
    end
    out_ready = 1'b1;
    step();
    check("drop_go_line", sflit, 0);
    check("drop_go_count", count, 0);
    for (int i = 0; i < 12; i++) step();
    check("drop_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("drop_rx0", rx_q[0], 8'h5A);
      check("drop_rx1", rx_q[1], 8'h77);
    end

    // Reset mid-frame with two flits queued.
    rx_q.delete();
    flit_valid = 1'b1; flit = 8'h0F; step();
    flit = 8'h81; step();
    flit = 8'h42; step();
    flit_valid = 1'b0; flit = 'x;
    for (int i = 0; i < 4; i++) step();
    check("rstmid_bit4", sflit, 0);
    check("rstmid_count", count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_line", sflit, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_cnt0", count, 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("post_rst%0d_line", i), sflit, 1);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_count", count, 0);
    check("post_rst_rx_n", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_flit_tx.md
Name: serial_flit_tx

Overview:
- Parallel-to-serial flit transmitter for one router port. It is the sending end of the one-bit serial flit link whose receive side is the router RX module.
- Accepts whole flits on a valid/ready parallel interface and buffers them in a small FIFO.
- Launches each flit as a framed bit stream on a one-bit line that idles high.
- A new frame starts only while the far-end receiver signals ready.

Parameters:
- FLIT_W, 32: flit width in bits; must be >= 2.
- FIFO_DEPTH, 4: flit buffer entries; power of two, >= 2.

Ports:
- clk, input, 1: single clock; everything samples on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flit_i, input, FLIT_W: parallel flit to send.
- flit_valid_i, input, 1: flit_i is valid this cycle.
- flit_ready_o, output, 1: FIFO can take a flit; equals !full.
- out_sflit_o, output, 1: serial line; registered; idle level 1.
- out_ready_i, input, 1: far-end receiver can accept a new flit.
- busy_o, output, 1: a frame is in progress (state != IDLE).
- fifo_count_o, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Frame format:
  - start bit 0;
  - FLIT_W data bits, LSB first, one bit per clk;
  - stop bit 1.
  - Frame length is FLIT_W+2 cycles.
- Reset state (asynchronous):
  - out_sflit_o=1, busy_o=0, fifo_count_o=0, flit_ready_o=1;
  - FSM in IDLE, bit counter 0, FIFO pointers 0.
- Push: at a rising edge with flit_valid_i && flit_ready_o.
  - flit_ready_o is purely !full; there is no bypass.
  - When full, ready stays low even if a pop occurs that same cycle.
- Launch condition L = fifo non-empty && out_ready_i, evaluated in IDLE or STOP.
- FSM:
  - IDLE: line 1. If L, at the edge: pop head into shift register, go to START.
  - START: line 0 for one cycle, then go to DATA with counter=0.
  - DATA: line = shift[0]. Each edge shifts right and increments the counter. After the bit with counter=FLIT_W-1, go to STOP.
  - STOP: line 1 for one cycle. If L, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Line output: out_sflit_o is the registered value of the state being entered, so the line is glitch-free.
- Latency: flit pushed at edge N into an empty FIFO, with FSM IDLE and out_ready_i=1:
  - start bit appears on out_sflit_o after edge N+1;
  - last data bit after edge N+1+FLIT_W.
- out_ready_i is sampled only at launch decisions. Deassertion mid-frame does not stall or abort the frame.
- Simultaneous push and pop in one cycle: occupancy unchanged, both take effect.
- fifo_count_o updates on the same edge as a push or pop.
- Counter widths:
  - bit counter is $clog2(FLIT_W) bits;
  - FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
- Reset asserted mid-frame:
  - line forced to 1 immediately, without waiting for clk;
  - FIFO contents and the in-flight flit are discarded.
  - The far end then sees a truncated frame; recovery is the system reset's job.
- X on flit_i while flit_valid_i=0 must not propagate into the FIFO.

Test Plan:
1. FLIT_W=8, out_ready_i=1, push 0xA5 at edge N -> out_sflit_o from edge N+1: 0,1,0,1,0,0,1,0,1,1, then stays 1; busy_o high for exactly 10 cycles.
2. out_ready_i=0, push 0x3C -> line stays 1, fifo_count_o=1, busy_o=0. Raise out_ready_i at edge M -> start bit after edge M+1, data 0,0,1,1,1,1,0,0.
3. out_ready_i=1, push 0x01,0x02,0x03,0x04 on consecutive cycles -> four contiguous 10-cycle frames with no idle cycle between them; fifo_count_o peaks at 3.
4. out_ready_i=0, push 5 flits with valid held -> flit_ready_o low after the 4th push, fifo_count_o=4, 5th flit not accepted. Then push and pop in the same cycle -> count stays 3.
5. Drop out_ready_i during a frame's DATA bit 3 -> frame completes unchanged. Next frame is not launched until out_ready_i=1 is seen in STOP or IDLE.
6. Assert reset during DATA bit 4 with 2 flits queued -> out_sflit_o=1 before the next clk edge. After release: fifo_count_o=0, busy_o=0, no further frames.
